// File: rtl/weight_fetch.sv
// weight_fetch: burst read initiator for one weight ROM port. It issues sequential addresses with credit-limited outstanding reads and returns the words in order through a small FIFO.
// Optional feature: define WEIGHT_FETCH_STRIDE_EN to add a per-command address stride input (cmd_stride).
module weight_fetch #(
    parameter int W_DATA          = 3,
    parameter int W_ADDR          = 12,
    parameter int W_CNT           = 12,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [W_ADDR-1:0] cmd_base,
    input  logic [W_CNT-1:0]  cmd_len,
`ifdef WEIGHT_FETCH_STRIDE_EN
    input  logic [W_ADDR-1:0] cmd_stride,
`endif
    output logic              addr1_valid,
    input  logic              addr1_ready,
    output logic [W_ADDR-1:0] addr1_data,
    input  logic              data1_valid,
    output logic              data1_ready,
    input  logic [W_DATA-1:0] data1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_DATA-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int OW = PW + 1;
    localparam logic [W_CNT-1:0] CNT_ONE = W_CNT'(1);
    localparam logic [PW:0]      PTR_ONE = (PW + 1)'(1);
    localparam logic [OW-1:0]    OUT_ONE = OW'(1);
    localparam logic [OW-1:0]    OUT_MAX = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t              state, state_next;
    logic [W_ADDR-1:0]   addr_q;
    logic [W_ADDR-1:0]   stride;
    logic [W_CNT-1:0]    len_q, issue_cnt, out_cnt;
    logic [OW-1:0]       outstanding;
    logic [W_DATA-1:0]   mem [MAX_OUTSTANDING];
    logic [PW:0]         wr_ptr, rd_ptr;
    logic                fifo_empty, fifo_full;
    logic                cmd_start, addr_fire, push, pop, last_issue;

    // cmd_ready is qualified by rst so it reads low for the whole reset pulse.
    assign cmd_ready   = (state == IDLE) && rst;
    assign cmd_start   = cmd_valid && cmd_ready && (cmd_len != '0);
    assign addr1_valid = (state == ISSUE) && (outstanding < OUT_MAX);
    assign addr1_data  = addr_q;
    assign addr_fire   = addr1_valid && addr1_ready;
    assign last_issue  = (issue_cnt == len_q - CNT_ONE);

    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign data1_ready = (state != IDLE) && !fifo_full;
    assign push        = data1_valid && data1_ready;
    assign out_valid   = !fifo_empty;
    assign out_data    = out_valid ? mem[rd_ptr[PW-1:0]] : '0;
    assign out_last    = out_valid && (out_cnt == len_q - CNT_ONE);
    assign pop         = out_valid && out_ready;
    assign busy        = (state != IDLE);

`ifdef WEIGHT_FETCH_STRIDE_EN
    logic [W_ADDR-1:0] stride_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           stride_q <= '0;
        else if (cmd_start) stride_q <= cmd_stride;
    end
    assign stride = stride_q;
`else
    assign stride = W_ADDR'(1);
`endif

    // NOTE: every output of a combinational block gets a default first, otherwise a missed branch infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_start)              state_next = ISSUE;
            ISSUE:   if (addr_fire && last_issue) state_next = DRAIN;
            DRAIN:   if (pop && out_last)        state_next = IDLE;
            default:                             state_next = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            issue_cnt   <= '0;
            out_cnt     <= '0;
            outstanding <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            state <= state_next;
            if (cmd_start) begin
                addr_q    <= cmd_base;
                len_q     <= cmd_len;
                issue_cnt <= '0;
                out_cnt   <= '0;
            end else begin
                if (addr_fire) begin
                    addr_q    <= addr_q + stride;
                    issue_cnt <= issue_cnt + CNT_ONE;
                end
                if (pop) out_cnt <= out_cnt + CNT_ONE;
            end
            // A credit is held from address issue until the word leaves on out.
            case ({addr_fire, pop})
                2'b10:   outstanding <= outstanding + OUT_ONE;
                2'b01:   outstanding <= outstanding - OUT_ONE;
                default: outstanding <= outstanding;
            endcase
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= data1;
    end

endmodule
